m_match_ctrl: RTL and testbench

M_MATCH_CTRL -- requirements
Module: m_match_ctrl

---
 rtl/match_pkg.sv | 39 +++
 rtl/m_win_check.sv | 65 ++++++
 rtl/m_match_ctrl.sv | 172 +++++++++++++++++
 tb/tb_m_match_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared codes for the match controller: buttons, modes, FSM states, winners and the
// disc-map bit index macro (row-major, row 0 at the bottom).
`ifndef MATCH_PKG_SV
`define MATCH_PKG_SV

`define MATCH_FIDX(row, col, cols) ((row) * (cols) + (col))

package match_pkg;

  localparam logic [3:0] BTN_INC = 4'b0001;
  localparam logic [3:0] BTN_DEC = 4'b0010;
  localparam logic [3:0] BTN_OK  = 4'b0100;

  localparam logic [1:0] MODE_HA = 2'b00;
  localparam logic [1:0] MODE_AH = 2'b01;
  localparam logic [1:0] MODE_HH = 2'b10;
  localparam logic [1:0] MODE_AA = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    ST_HUMAN   = 3'd0,
    ST_AI_WAIT = 3'd1,
    ST_DROP    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_OVER    = 3'd4
  } state_t;

  function automatic logic slot_is_ai(input logic [1:0] mode, input logic slot);
    if (slot) return (mode == MODE_HA) || (mode == MODE_AA);
    else      return (mode == MODE_AH) || (mode == MODE_AA);
  endfunction

endpackage

`endif

// File: rtl/m_win_check.sv
// Combinational WIN_LEN-in-a-row detector over one disc map (horizontal, vertical,
// both diagonals); zero latency, no flow control.
module m_win_check #(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4
) (
  input  logic [ROWS*COLS-1:0] i_field,
  output logic                 o_win
);

  localparam int N = ROWS * COLS;

  logic [N-1:0] h_hit, v_hit, d_hit, a_hit;

  // Every cell is the anchor (lowest row / leftmost end) of up to four candidate runs.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      localparam int B = gr * COLS + gc;

      if (gc + WIN_LEN <= COLS) begin : g_h
        logic [WIN_LEN-1:0] bits;
        for (genvar gk = 0; gk < WIN_LEN; gk++) begin : g_k
          assign bits[gk] = i_field[B + gk];
        end
        assign h_hit[B] = &bits;
      end else begin : g_hn
        assign h_hit[B] = 1'b0;
      end

      if (gr + WIN_LEN <= ROWS) begin : g_v
        logic [WIN_LEN-1:0] bits;
        for (genvar gk = 0; gk < WIN_LEN; gk++) begin : g_k
          assign bits[gk] = i_field[B + gk * COLS];
        end
        assign v_hit[B] = &bits;
      end else begin : g_vn
        assign v_hit[B] = 1'b0;
      end

      if ((gr + WIN_LEN <= ROWS) && (gc + WIN_LEN <= COLS)) begin : g_d
        logic [WIN_LEN-1:0] bits;
        for (genvar gk = 0; gk < WIN_LEN; gk++) begin : g_k
          assign bits[gk] = i_field[B + gk * (COLS + 1)];
        end
        assign d_hit[B] = &bits;
      end else begin : g_dn
        assign d_hit[B] = 1'b0;
      end

      if ((gr + WIN_LEN <= ROWS) && (gc >= WIN_LEN - 1)) begin : g_a
        logic [WIN_LEN-1:0] bits;
        for (genvar gk = 0; gk < WIN_LEN; gk++) begin : g_k
          assign bits[gk] = i_field[B + gk * (COLS - 1)];
        end
        assign a_hit[B] = &bits;
      end else begin : g_an
        assign a_hit[B] = 1'b0;
      end
    end
  end

  assign o_win = |{h_hit, v_hit, d_hit, a_hit};

endmodule

// File: rtl/m_match_ctrl.sv
// Connect-N match FSM: accepted move at N -> DROP N+1 -> CHECK N+2 -> next turn/OVER N+3.
// AI side handshakes via o_ai_req/i_ai_valid; MATCH_AI_TIMEOUT_EN adds an AI move timeout.
module m_match_ctrl
  import match_pkg::*;
#(
  parameter int COLS       = 7,
  parameter int ROWS       = 6,
  parameter int WIN_LEN    = 4,
  parameter int AI_TIMEOUT = 1000000
) (
  input  logic                    w_clk,
  input  logic                    w_rst,
  input  logic [1:0]              i_mode,
  input  logic [3:0]              i_btn,
  input  logic                    i_ai_valid,
  input  logic [$clog2(COLS)-1:0] i_ai_col,
  output logic                    o_ai_req,
  output logic [$clog2(COLS)-1:0] o_selecting_col,
  output logic [ROWS*COLS-1:0]    o_p0_field,
  output logic [ROWS*COLS-1:0]    o_p1_field,
  output logic                    o_turn,
  output logic [2:0]              o_state,
  output logic [1:0]              o_winner,
  output logic                    o_game_over
);

  localparam int CW = $clog2(COLS);
  localparam int N  = ROWS * COLS;
  localparam int HW = $clog2(ROWS + 1);
  localparam int IW = $clog2(N);
  localparam int MW = $clog2(N + 1);

  if (COLS < 2 || COLS > 15 || ROWS < 2 || ROWS > 15 || WIN_LEN < 2 ||
      WIN_LEN > COLS || WIN_LEN > ROWS || AI_TIMEOUT < 1) begin : g_param_chk
    $error("m_match_ctrl: parameter out of range");
  end

  state_t          state_q, state_nxt;
  logic [1:0]      mode_q;
  logic [N-1:0]    p0_q, p1_q;
  logic [HW-1:0]   height_q [COLS];
  logic [MW-1:0]   moves_q;
  logic            turn_q;
  logic [CW-1:0]   col_q;
  logic [1:0]      winner_q;

  logic            btn_inc, btn_dec, btn_ok;
  logic            mover_ai, next_ai, col_full, win, ai_take;
  logic [CW-1:0]   ai_col_pick;
  logic [IW-1:0]   drop_idx;
  logic [N-1:0]    drop_bit, mover_field;

  assign btn_inc = (i_btn == BTN_INC);
  assign btn_dec = (i_btn == BTN_DEC);
  assign btn_ok  = (i_btn == BTN_OK);

  assign mover_ai    = slot_is_ai(mode_q, turn_q);
  assign next_ai     = slot_is_ai(mode_q, ~turn_q);
  // An out-of-range AI column is treated exactly like a full one.
  assign col_full    = (int'(col_q) >= COLS) || (height_q[col_q] == HW'(ROWS));
  assign drop_idx    = `MATCH_FIDX(IW'(height_q[col_q]), IW'(col_q), IW'(COLS));
  assign drop_bit    = {{(N-1){1'b0}}, 1'b1} << drop_idx;
  assign mover_field = turn_q ? p1_q : p0_q;

  m_win_check #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .WIN_LEN (WIN_LEN)
  ) u_win_check (
    .i_field (mover_field),
    .o_win   (win)
  );

`ifdef MATCH_AI_TIMEOUT_EN
  localparam int TW = $clog2(AI_TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_hit;
  logic [CW-1:0] tmo_col;

  always_ff @(posedge w_clk) begin
    if (w_rst || state_q != ST_AI_WAIT) tmo_cnt_q <= '0;
    else                                tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign tmo_hit = (state_q == ST_AI_WAIT) && (tmo_cnt_q == TW'(AI_TIMEOUT - 1));

  always_comb begin
    tmo_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (height_q[c] != HW'(ROWS)) tmo_col = CW'(c);
    end
  end

  assign ai_take     = i_ai_valid || tmo_hit;
  assign ai_col_pick = i_ai_valid ? i_ai_col : tmo_col;
`else
  assign ai_take     = i_ai_valid;
  assign ai_col_pick = i_ai_col;
`endif

  always_ff @(posedge w_clk) begin
    if (w_rst) state_q <= slot_is_ai(i_mode, 1'b0) ? ST_AI_WAIT : ST_HUMAN;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_HUMAN:   if (btn_ok) state_nxt = ST_DROP;
      ST_AI_WAIT: if (ai_take) state_nxt = ST_DROP;
      ST_DROP: begin
        if (!col_full)     state_nxt = ST_CHECK;
        else if (mover_ai) state_nxt = ST_OVER;
        else               state_nxt = ST_HUMAN;
      end
      ST_CHECK: begin
        if (win || moves_q == MW'(N)) state_nxt = ST_OVER;
        else                          state_nxt = next_ai ? ST_AI_WAIT : ST_HUMAN;
      end
      ST_OVER: if (btn_ok) state_nxt = slot_is_ai(i_mode, 1'b0) ? ST_AI_WAIT : ST_HUMAN;
      default: state_nxt = ST_HUMAN;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst || (state_q == ST_OVER && btn_ok)) begin
      mode_q   <= i_mode;
      p0_q     <= '0;
      p1_q     <= '0;
      moves_q  <= '0;
      turn_q   <= 1'b0;
      col_q    <= '0;
      winner_q <= WIN_NONE;
      for (int c = 0; c < COLS; c++) height_q[c] <= '0;
    end else begin
      case (state_q)
        ST_HUMAN: begin
          if (btn_inc)      col_q <= (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
          else if (btn_dec) col_q <= (col_q == '0) ? CW'(COLS - 1) : col_q - 1'b1;
        end
        ST_AI_WAIT: if (ai_take) col_q <= ai_col_pick;
        ST_DROP: begin
          if (!col_full) begin
            if (turn_q) p1_q <= p1_q | drop_bit;
            else        p0_q <= p0_q | drop_bit;
            height_q[col_q] <= height_q[col_q] + 1'b1;
            moves_q         <= moves_q + 1'b1;
          end else if (mover_ai) begin
            winner_q <= turn_q ? WIN_P0 : WIN_P1;
          end
        end
        ST_CHECK: begin
          if (win)                     winner_q <= turn_q ? WIN_P1 : WIN_P0;
          else if (moves_q == MW'(N))  winner_q <= WIN_DRAW;
          else                         turn_q   <= ~turn_q;
        end
        default: ;
      endcase
    end
  end

  assign o_ai_req        = (state_q == ST_AI_WAIT);
  assign o_game_over     = (state_q == ST_OVER);
  assign o_state         = state_q;
  assign o_selecting_col = col_q;
  assign o_p0_field      = p0_q;
  assign o_p1_field      = p1_q;
  assign o_turn          = turn_q;
  assign o_winner        = winner_q;

endmodule

// File: tb/tb_m_match_ctrl.sv
// Directed bench for m_match_ctrl on the default 7x6 board, connect-4.
module tb_m_match_ctrl;

  localparam int COLS = 7;
  localparam int ROWS = 6;
  localparam int WIN_LEN = 4;
  localparam int AI_TIMEOUT = 16;

  localparam logic [3:0] INC = 4'b0001;
  localparam logic [3:0] DEC = 4'b0010;
  localparam logic [3:0] OK  = 4'b0100;
  localparam logic [63:0] ST_HUMAN = 64'd0;
  localparam logic [63:0] ST_AIW   = 64'd1;
  localparam logic [63:0] ST_DROP  = 64'd2;
  localparam logic [63:0] ST_CHECK = 64'd3;
  localparam logic [63:0] ST_OVER  = 64'd4;
  localparam logic [63:0] ALL42    = 64'h3FF_FFFF_FFFF;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b0;
  logic [1:0]  i_mode = 2'b10;
  logic [3:0]  i_btn = 4'b0;
  logic        i_ai_valid = 1'b0;
  logic [2:0]  i_ai_col = 3'd0;
  logic        o_ai_req;
  logic [2:0]  o_selecting_col;
  logic [41:0] o_p0_field, o_p1_field;
  logic        o_turn;
  logic [2:0]  o_state;
  logic [1:0]  o_winner;
  logic        o_game_over;

  int n_chk = 0;
  int n_err = 0;
  int cur = 0;
  logic [63:0] exp_p0;

  m_match_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .WIN_LEN(WIN_LEN), .AI_TIMEOUT(AI_TIMEOUT)
  ) dut (
    .w_clk(w_clk), .w_rst(w_rst), .i_mode(i_mode), .i_btn(i_btn),
    .i_ai_valid(i_ai_valid), .i_ai_col(i_ai_col), .o_ai_req(o_ai_req),
    .o_selecting_col(o_selecting_col), .o_p0_field(o_p0_field),
    .o_p1_field(o_p1_field), .o_turn(o_turn), .o_state(o_state),
    .o_winner(o_winner), .o_game_over(o_game_over)
  );

  always #5 w_clk = ~w_clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    i_btn = b;
    tick();
    i_btn = 4'b0;
  endtask

  task automatic do_reset(input logic [1:0] mode);
    i_mode = mode;
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    cur = 0;
  endtask

  task automatic move_to(input int col);
    while (cur != col) begin
      press(INC);
      cur = (cur + 1) % COLS;
    end
  endtask

  task automatic play(input int col);
    move_to(col);
    press(OK);
    tick();
    tick();
  endtask

  task automatic ai_move(input int col);
    chk_eq("ai_req_before_move", {63'd0, o_ai_req}, 64'd1);
    i_ai_valid = 1'b1;
    i_ai_col = 3'(col);
    tick();
    i_ai_valid = 1'b0;
    tick();
    tick();
    cur = col;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state, human-vs-human
    do_reset(2'b10);
    chk_eq("rst_state", 64'(o_state), ST_HUMAN);
    chk_eq("rst_p0", 64'(o_p0_field), 64'd0);
    chk_eq("rst_p1", 64'(o_p1_field), 64'd0);
    chk_eq("rst_turn", 64'(o_turn), 64'd0);
    chk_eq("rst_col", 64'(o_selecting_col), 64'd0);
    chk_eq("rst_winner", 64'(o_winner), 64'd0);
    chk_eq("rst_ai_req", 64'(o_ai_req), 64'd0);
    chk_eq("rst_game_over", 64'(o_game_over), 64'd0);

    // Cursor wrap and illegal button codes
    press(DEC);
    chk_eq("dec_wrap", 64'(o_selecting_col), 64'd6);
    press(INC);
    chk_eq("inc_wrap", 64'(o_selecting_col), 64'd0);
    press(4'b0011);
    chk_eq("btn_0011", 64'(o_selecting_col), 64'd0);
    press(4'b0110);
    chk_eq("btn_0110_state", 64'(o_state), ST_HUMAN);
    i_ai_valid = 1'b1; i_ai_col = 3'd3;
    tick();
    i_ai_valid = 1'b0;
    chk_eq("ai_valid_in_human_state", 64'(o_state), ST_HUMAN);
    chk_eq("ai_valid_in_human_col", 64'(o_selecting_col), 64'd0);

    // Vertical win for slot 0
    play(0); play(1); play(0); play(1); play(0); play(1);
    chk_eq("vwin_pre_state", 64'(o_state), ST_HUMAN);
    chk_eq("vwin_pre_turn", 64'(o_turn), 64'd0);
    move_to(0);
    press(OK);
    chk_eq("vwin_n1_state", 64'(o_state), ST_DROP);
    tick();
    chk_eq("vwin_n2_state", 64'(o_state), ST_CHECK);
    chk_eq("vwin_n2_bit21", 64'(o_p0_field[21]), 64'd1);
    tick();
    chk_eq("vwin_n3_winner", 64'(o_winner), 64'd1);
    chk_eq("vwin_n3_over", 64'(o_game_over), 64'd1);
    chk_eq("vwin_p0", 64'(o_p0_field), 64'h0020_4081);
    chk_eq("vwin_p1", 64'(o_p1_field), 64'h0000_8102);
    press(INC);
    chk_eq("over_inc_ignored", 64'(o_selecting_col), 64'd0);
    chk_eq("over_inc_state", 64'(o_state), ST_OVER);
    press(OK);
    chk_eq("restart_state", 64'(o_state), ST_HUMAN);
    chk_eq("restart_p0", 64'(o_p0_field), 64'd0);
    chk_eq("restart_winner", 64'(o_winner), 64'd0);
    cur = 0;

    // Full column: six discs in column 3, seventh OK rejected
    for (int i = 0; i < 6; i++) play(3);
    move_to(3);
    press(OK);
    chk_eq("full_n1_state", 64'(o_state), ST_DROP);
    tick();
    chk_eq("full_n2_state", 64'(o_state), ST_HUMAN);
    chk_eq("full_p0", 64'(o_p0_field), (64'd1 << 3) | (64'd1 << 17) | (64'd1 << 31));
    chk_eq("full_p1", 64'(o_p1_field), (64'd1 << 10) | (64'd1 << 24) | (64'd1 << 38));
    chk_eq("full_turn", 64'(o_turn), 64'd0);

    // Human-vs-AI handshake and forfeit on a full column
    do_reset(2'b00);
    chk_eq("ha_rst_state", 64'(o_state), ST_HUMAN);
    play(2);
    chk_eq("ha_ai_req", 64'(o_ai_req), 64'd1);
    chk_eq("ha_turn", 64'(o_turn), 64'd1);
    tick(); tick();
    chk_eq("ha_ai_req_held", 64'(o_ai_req), 64'd1);
    i_ai_valid = 1'b1; i_ai_col = 3'd5;
    tick();
    i_ai_valid = 1'b0;
    chk_eq("ha_ai_req_dropped", 64'(o_ai_req), 64'd0);
    chk_eq("ha_col_latched", 64'(o_selecting_col), 64'd5);
    tick();
    chk_eq("ha_p1_bit5", 64'(o_p1_field), 64'h20);
    tick();
    chk_eq("ha_back_human", 64'(o_state), ST_HUMAN);
    cur = 5;
    play(0); ai_move(0); play(0); ai_move(0); play(0); ai_move(0);
    play(3);
    chk_eq("forfeit_ai_req", 64'(o_ai_req), 64'd1);
    i_ai_valid = 1'b1; i_ai_col = 3'd0;
    tick();
    i_ai_valid = 1'b0;
    chk_eq("forfeit_n1_state", 64'(o_state), ST_DROP);
    tick();
    chk_eq("forfeit_state", 64'(o_state), ST_OVER);
    chk_eq("forfeit_winner", 64'(o_winner), 64'd1);
    chk_eq("forfeit_p1", 64'(o_p1_field),
           (64'd1 << 5) | (64'd1 << 7) | (64'd1 << 21) | (64'd1 << 35));

    // Reset while the AI is answering abandons the move
    do_reset(2'b00);
    play(4);
    i_ai_valid = 1'b1; i_ai_col = 3'd1; w_rst = 1'b1;
    tick();
    i_ai_valid = 1'b0; w_rst = 1'b0; cur = 0;
    chk_eq("rst_mid_p0", 64'(o_p0_field), 64'd0);
    chk_eq("rst_mid_p1", 64'(o_p1_field), 64'd0);
    chk_eq("rst_mid_state", 64'(o_state), ST_HUMAN);
    do_reset(2'b01);
    chk_eq("rst_ah_state", 64'(o_state), ST_AIW);
    chk_eq("rst_ah_ai_req", 64'(o_ai_req), 64'd1);

    // Non-winning full-board fill ends in a draw; mode change mid-game is ignored
    do_reset(2'b10);
    for (int i = 0; i < 6; i++) play(5);
    i_mode = 2'b11;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 3; k++) begin
        play(p == 2 ? 4 : p);
        play(p == 2 ? 6 : p + 2);
        play(p == 2 ? 6 : p + 2);
        play(p == 2 ? 4 : p);
      end
    end
    exp_p0 = 64'd0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (((r + (((c % 4) >= 2) ? 1 : 0)) % 2) == 0) exp_p0[r * COLS + c] = 1'b1;
    chk_eq("draw_winner", 64'(o_winner), 64'd3);
    chk_eq("draw_over", 64'(o_game_over), 64'd1);
    chk_eq("draw_p0", 64'(o_p0_field), exp_p0);
    chk_eq("draw_p1", 64'(o_p1_field), ALL42 & ~exp_p0);
    i_mode = 2'b10;
    press(OK);
    chk_eq("draw_restart_state", 64'(o_state), ST_HUMAN);
    chk_eq("draw_restart_p0", 64'(o_p0_field), 64'd0);
    chk_eq("draw_restart_p1", 64'(o_p1_field), 64'd0);
    chk_eq("draw_restart_winner", 64'(o_winner), 64'd0);
    chk_eq("draw_restart_turn", 64'(o_turn), 64'd0);
    chk_eq("draw_restart_over", 64'(o_game_over), 64'd0);

`ifdef MATCH_AI_TIMEOUT_EN
    // Silent AI: timeout plays the lowest non-full column
    do_reset(2'b01);
    for (int i = 0; i < AI_TIMEOUT; i++) tick();
    chk_eq("tmo_drop_state", 64'(o_state), ST_DROP);
    tick();
    chk_eq("tmo_p0", 64'(o_p0_field), 64'd1);
    chk_eq("tmo_check_state", 64'(o_state), ST_CHECK);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
